// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the CNN digit core: core reset, pixel streaming from a sync RAM, result capture.
// Optional WAIT_DONE watchdog is enabled by defining CNN_SEQ_WATCHDOG_EN.
module cnn_frame_sequencer #(
  parameter int IMG_PIX = 784,
  parameter int PIX_W   = 9,
  parameter int PRE_RST = 20,
  parameter int TIMEOUT = 2000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [9:0]              pix_addr,
  output logic                    pix_rd,
  input  logic signed [PIX_W-1:0] pix_data,
  output logic                    core_rst,
  output logic signed [PIX_W-1:0] core_pix,
  output logic                    core_pix_vld,
  input  logic                    core_done,
  input  logic [3:0]              core_digit,
  output logic [3:0]              result,
  output logic                    result_vld,
  output logic                    done,
  output logic                    err,
  output logic [15:0]             frame_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRERST = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // One counter serves the PRERST countdown and the WAIT_DONE watchdog.
  localparam int CNT_MAX = (PRE_RST > TIMEOUT) ? PRE_RST : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pix_addr_q, pix_addr_d;
  logic             pix_rd_q, pix_rd_d;
  logic             core_rst_q, core_rst_d;
  logic             core_pix_vld_q, core_pix_vld_d;
  logic [3:0]       result_q, result_d;
  logic             result_vld_q, result_vld_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`ifdef CNN_SEQ_WATCHDOG_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pix_addr_d   = pix_addr_q;
    pix_rd_d     = 1'b0;
    result_d     = result_q;
    result_vld_d = result_vld_q;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;
`ifdef CNN_SEQ_WATCHDOG_EN
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PRERST;
          cnt_d        = CNT_W'(PRE_RST - 1);
          result_vld_d = 1'b0;
`ifdef CNN_SEQ_WATCHDOG_EN
          err_d        = 1'b0;
`endif
        end
      end
      S_PRERST: begin
        if (cnt_q == '0) begin
          state_d    = S_STREAM;
          pix_rd_d   = 1'b1;
          pix_addr_d = 10'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (pix_addr_q == 10'(IMG_PIX - 1)) begin
          state_d    = S_WAIT;
          pix_addr_d = 10'd0;
          cnt_d      = '0;
        end else begin
          pix_addr_d = pix_addr_q + 10'd1;
          pix_rd_d   = 1'b1;
        end
      end
      S_WAIT: begin
        // A strobe coinciding with the timeout still counts as success.
        if (core_done) begin
          state_d      = S_FINISH;
          result_d     = core_digit;
          result_vld_d = 1'b1;
          done_d       = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
`ifdef CNN_SEQ_WATCHDOG_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_FINISH;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // The RAM output register is the pixel stage; vld trails the read by one cycle.
    core_pix_vld_d = pix_rd_q;
    core_rst_d     = !((state_q == S_STREAM) || ((state_q == S_WAIT) && (state_d == S_WAIT)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pix_addr_q     <= 10'd0;
      pix_rd_q       <= 1'b0;
      core_rst_q     <= 1'b1;
      core_pix_vld_q <= 1'b0;
      result_q       <= 4'd0;
      result_vld_q   <= 1'b0;
      done_q         <= 1'b0;
      frame_cnt_q    <= 16'd0;
`ifdef CNN_SEQ_WATCHDOG_EN
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pix_addr_q     <= pix_addr_d;
      pix_rd_q       <= pix_rd_d;
      core_rst_q     <= core_rst_d;
      core_pix_vld_q <= core_pix_vld_d;
      result_q       <= result_d;
      result_vld_q   <= result_vld_d;
      done_q         <= done_d;
      frame_cnt_q    <= frame_cnt_d;
`ifdef CNN_SEQ_WATCHDOG_EN
      err_q          <= err_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign pix_addr     = pix_addr_q;
  assign pix_rd       = pix_rd_q;
  assign core_rst     = core_rst_q;
  assign core_pix_vld = core_pix_vld_q;
  assign core_pix     = core_pix_vld_q ? pix_data : '0;
  assign result       = result_q;
  assign result_vld   = result_vld_q;
  assign done         = done_q;
  assign frame_cnt    = frame_cnt_q;
`ifdef CNN_SEQ_WATCHDOG_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: vector table for reset + nominal frame, hand sequences for corners.
module tb_cnn_frame_sequencer;
  localparam int PIX_W   = 9;
  localparam int IMG_PIX = 784;
  localparam int PRE_RST = 20;
  localparam int TIMEOUT = 100;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    start = 1'b0;
  logic                    busy;
  logic [9:0]              pix_addr;
  logic                    pix_rd;
  logic signed [PIX_W-1:0] pix_data = '0;
  logic                    core_rst;
  logic signed [PIX_W-1:0] core_pix;
  logic                    core_pix_vld;
  logic                    core_done = 1'b0;
  logic [3:0]              core_digit = 4'd0;
  logic [3:0]              result;
  logic                    result_vld;
  logic                    done;
  logic                    err;
  logic [15:0]             frame_cnt;

  cnn_frame_sequencer #(
    .IMG_PIX(IMG_PIX), .PIX_W(PIX_W), .PRE_RST(PRE_RST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_data(pix_data),
    .core_rst(core_rst), .core_pix(core_pix), .core_pix_vld(core_pix_vld),
    .core_done(core_done), .core_digit(core_digit),
    .result(result), .result_vld(result_vld), .done(done), .err(err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous pixel RAM: word k holds k mod 256.
  always @(posedge clk)
    if (pix_rd) pix_data <= PIX_W'(pix_addr & 10'h0FF);

  int total = 0;
  int bad = 0;
  int vld_len = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel stream monitor: each presented pixel must be the next ramp value, with the core out of reset.
  always @(negedge clk) begin
    if (rst && core_pix_vld) begin
      chk("core_pix", 32'($unsigned(core_pix)), 32'(vld_len % 256));
      chk("core_rst_with_vld", 32'(core_rst), 32'd0);
      vld_len++;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic       rst, start, cdone;
    logic [3:0] digit;
    int         cyc;
    logic       busy, crst, rd, vld;
    logic [3:0] res;
    logic       rv, dn;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[13];

  task automatic stream_frame(input bit spurious);
    bit seen_rd = 1'b0;
    bit injected = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (spurious && !injected && vld_len >= 100) begin
        start = 1'b1; core_done = 1'b1; core_digit = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; core_done = 1'b0;
        injected = 1'b1;
        chk("spur_busy", 32'(busy), 32'd1);
        chk("spur_rd", 32'(pix_rd), 32'd1);
        chk("spur_rv", 32'(result_vld), 32'd0);
        chk("spur_res", 32'(result), 32'd7);
        chk("spur_done", 32'(done), 32'd0);
      end
      if (pix_rd) seen_rd = 1'b1;
      else if (seen_rd) break;
    end
    chk("wait_entry", 32'({seen_rd, pix_rd}), 32'b10);
    @(posedge clk); #1;
    chk("vld_len", 32'(vld_len), 32'(IMG_PIX));
    chk("vld_off", 32'(core_pix_vld), 32'd0);
    chk("pix_zero", 32'($unsigned(core_pix)), 32'd0);
  endtask

  task automatic finish_frame(input logic [3:0] digit, input logic [15:0] fc);
    core_done = 1'b1; core_digit = digit;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_result", 32'(result), 32'(digit));
    chk("fin_rv", 32'(result_vld), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_core_rst", 32'(core_rst), 32'd1);
    chk("fin_frame_cnt", 32'(frame_cnt), 32'(fc));
    chk("fin_err", 32'(err), 32'd0);
  endtask

  initial begin
    int saved;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 2,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 3,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'd0, 1,   1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 19,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1,   1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1,   1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 782, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1,   1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1,   1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 10,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 4'd7, 1,   1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 1,   1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 16'd1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 3,   1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 16'd1};

    // Reset and nominal frame, cycle-exact
    for (int v = 0; v < 13; v++) begin
      rst = tbl[v].rst; start = tbl[v].start;
      core_done = tbl[v].cdone; core_digit = tbl[v].digit;
      repeat (tbl[v].cyc) @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      chk($sformatf("v%0d_core_rst", v), 32'(core_rst), 32'(tbl[v].crst));
      chk($sformatf("v%0d_pix_rd", v), 32'(pix_rd), 32'(tbl[v].rd));
      chk($sformatf("v%0d_vld", v), 32'(core_pix_vld), 32'(tbl[v].vld));
      chk($sformatf("v%0d_result", v), 32'(result), 32'(tbl[v].res));
      chk($sformatf("v%0d_rv", v), 32'(result_vld), 32'(tbl[v].rv));
      chk($sformatf("v%0d_done", v), 32'(done), 32'(tbl[v].dn));
      chk($sformatf("v%0d_frame_cnt", v), 32'(frame_cnt), 32'(tbl[v].fc));
      chk($sformatf("v%0d_err", v), 32'(err), 32'd0);
      if (v == 0) chk("reset_pix_addr", 32'(pix_addr), 32'd0);
    end
    chk("nom_vld_len", 32'(vld_len), 32'(IMG_PIX));
    chk("nom_done_cnt", 32'(done_cnt), 32'd1);

    // Spurious start and core_done while streaming
    vld_len = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("f2_rv_cleared", 32'(result_vld), 32'd0);
    stream_frame(1'b1);
    finish_frame(4'd5, 16'd2);
    @(posedge clk); #1;
    chk("f2_idle", 32'(busy), 32'd0);
    chk("f2_done_cnt", 32'(done_cnt), 32'd2);

    // Reset in the middle of the pixel stream
    vld_len = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 2000 && vld_len < 400; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_400", 32'(vld_len >= 400), 32'd1);
    saved = done_cnt;
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_pix_rd", 32'(pix_rd), 32'd0);
    chk("abort_vld", 32'(core_pix_vld), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done_cnt), 32'(saved));
    vld_len = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    stream_frame(1'b0);
    finish_frame(4'd2, 16'd1);
    @(posedge clk); #1;

    // WAIT_DONE with no strobe from the core
    vld_len = 0;
    saved = done_cnt;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    stream_frame(1'b0);
`ifdef CNN_SEQ_WATCHDOG_EN
    begin
      int n = 1;
      while (n < 500 && !done) begin
        @(posedge clk); #1;
        n++;
      end
      chk("wd_latency", 32'(n), 32'(TIMEOUT));
      chk("wd_err", 32'(err), 32'd1);
      chk("wd_rv", 32'(result_vld), 32'd0);
      chk("wd_result", 32'(result), 32'd2);
      chk("wd_frame_cnt", 32'(frame_cnt), 32'd1);
      @(posedge clk); #1;
      chk("wd_idle", 32'(busy), 32'd0);
      chk("wd_err_held", 32'(err), 32'd1);
      chk("wd_done_cnt", 32'(done_cnt), 32'(saved + 1));
    end
`else
    repeat (300) @(posedge clk);
    #1;
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_no_done", 32'(done_cnt), 32'(saved));
    chk("nowd_err", 32'(err), 32'd0);
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    chk("nowd_reset_busy", 32'(busy), 32'd0);
`endif

    // Back-to-back frames with start held, frame_cnt wrapping
    force dut.frame_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    @(posedge clk); #1;
    chk("wrap_preset", 32'(frame_cnt), 32'hFFFE);
    vld_len = 0;
    start = 1'b1; @(posedge clk); #1;
    chk("wrap_a_busy", 32'(busy), 32'd1);
    chk("wrap_a_err_clr", 32'(err), 32'd0);
    chk("wrap_a_rv_clr", 32'(result_vld), 32'd0);
    stream_frame(1'b0);
    finish_frame(4'd9, 16'hFFFF);
    @(posedge clk); #1;
    chk("wrap_gap_idle", 32'(busy), 32'd0);
    vld_len = 0;
    @(posedge clk); #1;
    chk("wrap_b_restart", 32'(busy), 32'd1);
    chk("wrap_b_rv_clr", 32'(result_vld), 32'd0);
    start = 1'b0;
    stream_frame(1'b0);
    finish_frame(4'd1, 16'h0000);
    @(posedge clk); #1;
    chk("wrap_end_idle", 32'(busy), 32'd0);
    chk("wrap_end_cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Frame-level controller for the CNN digit-classification core. On a start request it holds the core in reset, streams one 28x28 image from a synchronous pixel RAM into the core one pixel per clock, waits for the core's classification-done strobe, and latches the 4-bit digit result for the host. It sits between the host/frame-buffer side and `main_program`, replacing testbench-driven reset and pixel sequencing.

## Interface
Parameters:
- IMG_PIX, 784, pixels per frame (28x28)
- PIX_W, 9, pixel width (signed, matches core input)
- PRE_RST, 20, cycles core_rst held high before streaming (≥1)
- TIMEOUT, 2000000, max WAIT_DONE cycles (used only with watchdog)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request one frame; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- pix_addr  out  10  pixel RAM read address
- pix_rd  out  1  pixel RAM read enable
- pix_data  in  PIX_W  RAM read data, valid 1 cycle after pix_rd
- core_rst  out  1  core reset, active-high
- core_pix  out  PIX_W  pixel to core
- core_pix_vld  out  1  core_pix carries a frame pixel
- core_done  in  1  core classification strobe (En4)
- core_digit  in  4  core result (ma)
- result  out  4  latched digit
- result_vld  out  1  result valid, held until next accepted start
- done  out  1  1-cycle pulse at frame completion (success or error)
- err  out  1  last frame timed out; held until next accepted start
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, PRERST, STREAM, WAIT_DONE, FINISH.
- IDLE: core_rst=1, outputs quiescent. start=1 → PRERST; clears result_vld, err; loads counter PRE_RST-1.
- PRERST: core_rst=1, counts down; at 0 → STREAM, pix_rd=1, pix_addr=0 issued in the same transition cycle.
- STREAM: pix_addr increments 0..IMG_PIX-1, one per cycle, pix_rd=1. core_pix/core_pix_vld are registered copies of pix_data one cycle after each read. After address IMG_PIX-1 is issued → WAIT_DONE.
- core_rst deasserts in the same cycle core_pix_vld first goes high (pixel 0), and stays low until FINISH.
- WAIT_DONE: pix_rd=0; last pixel presented in first WAIT_DONE cycle, thereafter core_pix=0, core_pix_vld=0. core_done=1 → latch core_digit into result, → FINISH.
- core_done during PRERST or STREAM is ignored (no latch, no state change).
- FINISH (1 cycle): done=1, result_vld=1 (success), frame_cnt+1 on success only, core_rst=1 → IDLE.
- start outside IDLE ignored. start held high re-triggers a new frame the cycle after FINISH returns to IDLE.
- rst=0 at any point: next edge all state/outputs to reset values; frame in progress abandoned, no done.

## Timing
- Reset values: busy=0, pix_addr=0, pix_rd=0, core_rst=1, core_pix=0, core_pix_vld=0, result=0, result_vld=0, done=0, err=0, frame_cnt=0, state IDLE.
- start at edge N → busy=1 at N+1; first pix_rd at N+1+PRE_RST; core_pix_vld high for exactly IMG_PIX consecutive cycles starting one cycle later.
- core_done at edge M → result/result_vld/done visible at M+1; busy=0 at M+2.
- Minimum frame latency, start to done, = 1 + PRE_RST + IMG_PIX + 1 + core latency + 1 cycles.

## Configuration
- CNN_SEQ_WATCHDOG_EN defined: WAIT_DONE counter counts cycles; on reaching TIMEOUT without core_done → FINISH with err=1, result_vld=0, result unchanged, done=1, frame_cnt not incremented. core_done on the same cycle as timeout wins (success).
- Undefined: no counter, WAIT_DONE waits indefinitely; err tied 0.

## Test plan
- Reset: rst=0 two cycles → all outputs at reset values; core_rst=1, busy=0.
- Nominal frame, PRE_RST=20, RAM pixel k = k mod 256: core_pix_vld exactly 784 cycles, core_pix sequence 0,1,…,255,0…; core_rst falls with first vld; core_done with digit 7 → result=7, result_vld=1, one done pulse, frame_cnt=1.
- start pulsed during STREAM and spurious core_done during STREAM → no restart, no latch; pixel stream uninterrupted.
- Mid-STREAM rst=0 at pixel 400 → next cycle IDLE, core_rst=1, no done; subsequent start runs full 784-pixel frame.
- Watchdog (macro on, TIMEOUT=100): no core_done → done pulse exactly 100 cycles after WAIT_DONE entry, err=1, result_vld=0, frame_cnt unchanged; macro off → busy stays high indefinitely.
- start held high, frame_cnt preset via 0xFFFF completed frames (or forced) → back-to-back frames, frame_cnt wraps to 0.
